// File: rtl/vga_sync_gen_pkg.sv
// vga_sync_gen_pkg: default 800x600@60 timing constants and region classification shared by the VGA pipeline
package vga_sync_gen_pkg;
  localparam logic [10:0] H_SYNC_D   = 11'd128;
  localparam logic [10:0] H_BP_D     = 11'd88;
  localparam logic [10:0] H_ACTIVE_D = 11'd800;
  localparam logic [10:0] H_FP_D     = 11'd40;
  localparam logic [10:0] V_SYNC_D   = 11'd4;
  localparam logic [10:0] V_BP_D     = 11'd23;
  localparam logic [10:0] V_ACTIVE_D = 11'd600;
  localparam logic [10:0] V_FP_D     = 11'd1;
  localparam logic        SYNC_POL_D = 1'b1;
  typedef enum logic [1:0] {REG_SYNC, REG_BP, REG_ACTIVE, REG_FP} region_e;
  function automatic region_e region_of(input logic [10:0] c, s, b, a);
    return c < s ? REG_SYNC : c < s + b ? REG_BP : c < s + b + a ? REG_ACTIVE : REG_FP;
  endfunction
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: timing bundle from the sync generator to display consumers
// frame_start is only present when VGA_FRAME_TICK_EN is defined
interface vga_sync_gen_if;
  logic        hsync;
  logic        vsync;
  logic        ready_sig;
  logic [10:0] col_addr_sig;
  logic [10:0] row_addr_sig;
`ifdef VGA_FRAME_TICK_EN
  logic        frame_start;
`endif
  modport master(output hsync, vsync, ready_sig, col_addr_sig, row_addr_sig
`ifdef VGA_FRAME_TICK_EN
    , output frame_start
`endif
  );
  modport slave(input hsync, vsync, ready_sig, col_addr_sig, row_addr_sig
`ifdef VGA_FRAME_TICK_EN
    , input frame_start
`endif
  );
endinterface

// File: rtl/vga_line_counter.sv
// vga_line_counter: enabled wrap counter 0..TOTAL-1; wrap flags the enabled terminal-count cycle
module vga_line_counter #(
  parameter logic [10:0] TOTAL = 11'd1056
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] cnt,
  output logic        wrap
);
  assign wrap = en && cnt == TOTAL - 11'd1;
  always_ff @(posedge clk)
    cnt <= rst || wrap ? 11'd0 : en ? cnt + 11'd1 : cnt;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA timing generator; all outputs registered once from the counters
// Define VGA_FRAME_TICK_EN to add the frame_start pulse
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter logic [10:0] H_SYNC   = H_SYNC_D,
  parameter logic [10:0] H_BP     = H_BP_D,
  parameter logic [10:0] H_ACTIVE = H_ACTIVE_D,
  parameter logic [10:0] H_FP     = H_FP_D,
  parameter logic [10:0] V_SYNC   = V_SYNC_D,
  parameter logic [10:0] V_BP     = V_BP_D,
  parameter logic [10:0] V_ACTIVE = V_ACTIVE_D,
  parameter logic [10:0] V_FP     = V_FP_D,
  parameter logic        SYNC_POL = SYNC_POL_D
) (
  input  logic         clk,
  input  logic         rst,
  vga_sync_gen_if.master vga
);
  localparam logic [10:0] H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam logic [10:0] V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  logic [10:0] h_cnt, v_cnt;
  logic        h_wrap, v_wrap_unused;
  region_e     h_reg, v_reg;
  logic        active;
  vga_line_counter #(.TOTAL(H_TOTAL)) u_h (
    .clk(clk), .rst(rst), .en(1'b1), .cnt(h_cnt), .wrap(h_wrap)
  );
  vga_line_counter #(.TOTAL(V_TOTAL)) u_v (
    .clk(clk), .rst(rst), .en(h_wrap), .cnt(v_cnt), .wrap(v_wrap_unused)
  );
  always_comb begin
    h_reg  = region_of(h_cnt, H_SYNC, H_BP, H_ACTIVE);
    v_reg  = region_of(v_cnt, V_SYNC, V_BP, V_ACTIVE);
    active = h_reg == REG_ACTIVE && v_reg == REG_ACTIVE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vga.hsync        <= ~SYNC_POL;
      vga.vsync        <= ~SYNC_POL;
      vga.ready_sig    <= 1'b0;
      vga.col_addr_sig <= 11'd0;
      vga.row_addr_sig <= 11'd0;
    end else begin
      vga.hsync        <= h_reg == REG_SYNC ? SYNC_POL : ~SYNC_POL;
      vga.vsync        <= v_reg == REG_SYNC ? SYNC_POL : ~SYNC_POL;
      vga.ready_sig    <= active;
      vga.col_addr_sig <= active ? h_cnt - (H_SYNC + H_BP) : 11'd0;
      vga.row_addr_sig <= active ? v_cnt - (V_SYNC + V_BP) : 11'd0;
    end
  end
`ifdef VGA_FRAME_TICK_EN
  always_ff @(posedge clk)
    vga.frame_start <= !rst && h_cnt == 11'd0 && v_cnt == 11'd0;
`endif
endmodule
